// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment bus order is {dp,g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         DP_BIT    = 7;

    // Glyphs in {g,f,e,d,c,b,a} order, indexed by hex value 0..F.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        GUARD
    } seg7_state_e;

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational hex nibble to seven-segment glyph, {g..a} order.
module seg7_hex_encode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = HEX_GLYPH[i_nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered display value
// that is only replaced at frame boundaries, so a frame never mixes two values.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    LoadValid,
    output logic                    LoadReady,
    input  logic [4*NUM_DIGITS-1:0] LoadValue,
    input  logic [NUM_DIGITS-1:0]   LoadDp,
    input  logic                    BlankLeading,
    output logic [7:0]              SegOut,
    output logic [NUM_DIGITS-1:0]   DigitEn,
    output logic                    FrameDone
);

    localparam int MAX_PHASE = (DWELL_CYCLES >= GUARD_CYCLES) ?
                               ((DWELL_CYCLES > 1) ? DWELL_CYCLES : 1) : GUARD_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    seg7_state_e               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;

    logic [4*NUM_DIGITS-1:0]   r_disp_val;
    logic [NUM_DIGITS-1:0]     r_disp_dp;
    logic                      r_disp_blank;

    logic                      r_pend_full;
    logic [4*NUM_DIGITS-1:0]   r_pend_val;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic                      r_pend_blank;

    logic [7:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_digit_en;
    logic                      r_frame_done;

    seg7_state_e               w_nxt_state;
    logic [CNT_W-1:0]          w_nxt_cnt;
    logic [IDX_W-1:0]          w_nxt_idx;
    logic                      w_digit_end;
    logic                      w_commit;
    logic                      w_xfer;

    logic [4*NUM_DIGITS-1:0]   w_nxt_val;
    logic [NUM_DIGITS-1:0]     w_nxt_dp;
    logic                      w_nxt_blank;

    logic [3:0]                w_nibble;
    logic                      w_dp;
    logic                      w_upper_zero;
    logic                      w_blank;
    logic [NUM_DIGITS-1:0]     w_onehot;
    logic [6:0]                w_glyph;
    logic [7:0]                w_seg_nxt;

    function automatic logic f_is_boundary(input seg7_state_e st,
                                           input logic [CNT_W-1:0] cnt,
                                           input logic [IDX_W-1:0] idx);
        if (GUARD_CYCLES == 0)
            return (idx == IDX_LAST) && (st == DWELL) && (cnt == DWELL_LAST);
        else
            return (idx == IDX_LAST) && (st == GUARD) && (cnt == GUARD_LAST);
    endfunction

    assign w_xfer = LoadValid && !r_pend_full;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_idx   = r_idx;
        w_commit    = 1'b0;
        w_digit_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pend_full) begin
                    w_commit    = 1'b1;
                    w_nxt_state = DWELL;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = '0;
                end
            end
            DWELL: begin
                if (r_cnt == DWELL_LAST) begin
                    if (GUARD_CYCLES == 0) begin
                        w_digit_end = 1'b1;
                    end else begin
                        w_nxt_state = GUARD;
                        w_nxt_cnt   = '0;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            GUARD: begin
                if (r_cnt == GUARD_LAST)
                    w_digit_end = 1'b1;
                else
                    w_nxt_cnt = r_cnt + 1'b1;
            end
            default: w_nxt_state = IDLE;
        endcase
        // Last digit's exit is the frame boundary: wrap and take the pending value.
        if (w_digit_end) begin
            w_nxt_state = DWELL;
            w_nxt_cnt   = '0;
            if (r_idx == IDX_LAST) begin
                w_nxt_idx = '0;
                w_commit  = r_pend_full;
            end else begin
                w_nxt_idx = r_idx + 1'b1;
            end
        end
    end

    // Outputs are registered, so glyph selection looks at next-cycle state and value.
    assign w_nxt_val   = w_commit ? r_pend_val   : r_disp_val;
    assign w_nxt_dp    = w_commit ? r_pend_dp    : r_disp_dp;
    assign w_nxt_blank = w_commit ? r_pend_blank : r_disp_blank;

    always_comb begin
        w_nibble     = '0;
        w_dp         = 1'b0;
        w_onehot     = '0;
        w_upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (w_nxt_idx == IDX_W'(i)) begin
                w_nibble    = w_nxt_val[4*i +: 4];
                w_dp        = w_nxt_dp[i];
                w_onehot[i] = 1'b1;
            end
            if ((IDX_W'(i) >= w_nxt_idx) && (w_nxt_val[4*i +: 4] != 4'h0))
                w_upper_zero = 1'b0;
        end
    end

    assign w_blank = w_nxt_blank && w_upper_zero && (w_nxt_idx != '0);

    seg7_hex_encode u_hex_encode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_seg_nxt         = SEG_BLANK;
        w_seg_nxt[6:0]    = w_blank ? 7'h00 : w_glyph;
        w_seg_nxt[DP_BIT] = w_dp;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= 1'b0;
            r_pend_full  <= 1'b0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= 1'b0;
            r_seg        <= SEG_BLANK;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_idx   <= w_nxt_idx;
            if (w_commit) begin
                r_disp_val   <= r_pend_val;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
                r_pend_full  <= 1'b0;
            end
            if (w_xfer) begin
                r_pend_val   <= LoadValue;
                r_pend_dp    <= LoadDp;
                r_pend_blank <= BlankLeading;
                r_pend_full  <= 1'b1;
            end
            if (w_nxt_state == DWELL) begin
                r_seg      <= w_seg_nxt;
                r_digit_en <= w_onehot;
            end else begin
                r_seg      <= SEG_BLANK;
                r_digit_en <= '0;
            end
            r_frame_done <= f_is_boundary(w_nxt_state, w_nxt_cnt, w_nxt_idx);
        end
    end

    assign LoadReady = !r_pend_full;
    assign SegOut    = r_seg;
    assign DigitEn   = r_digit_en;
    assign FrameDone = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl: three configurations run in lockstep against
// a frame-position reference model (time within frame -> digit, phase, glyph).
module tb_seg7_scan_ctrl;

    localparam int NI = 3;
    localparam int N0 = 2, D0 = 4, G0 = 1;
    localparam int N1 = 4, D1 = 3, G1 = 2;
    localparam int N2 = 2, D2 = 3, G2 = 0;
    localparam int P_N [NI] = '{N0, N1, N2};
    localparam int P_D [NI] = '{D0, D1, D2};
    localparam int P_G [NI] = '{G0, G1, G2};
    localparam int NUM_CYCLES = 3000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [NI];
    logic        valid [NI];
    logic        blank [NI];
    logic [31:0] val   [NI];
    logic [7:0]  dp    [NI];

    logic [7:0]    seg0, seg1, seg2;
    logic [N0-1:0] en0;
    logic [N1-1:0] en1;
    logic [N2-1:0] en2;
    logic          fd0, fd1, fd2, rdy0, rdy1, rdy2;

    seg7_scan_ctrl #(.NUM_DIGITS(N0), .DWELL_CYCLES(D0), .GUARD_CYCLES(G0)) u_dut0 (
        .Clk(clk), .Rst(rst[0]), .LoadValid(valid[0]), .LoadReady(rdy0),
        .LoadValue(val[0][4*N0-1:0]), .LoadDp(dp[0][N0-1:0]), .BlankLeading(blank[0]),
        .SegOut(seg0), .DigitEn(en0), .FrameDone(fd0)
    );
    seg7_scan_ctrl #(.NUM_DIGITS(N1), .DWELL_CYCLES(D1), .GUARD_CYCLES(G1)) u_dut1 (
        .Clk(clk), .Rst(rst[1]), .LoadValid(valid[1]), .LoadReady(rdy1),
        .LoadValue(val[1][4*N1-1:0]), .LoadDp(dp[1][N1-1:0]), .BlankLeading(blank[1]),
        .SegOut(seg1), .DigitEn(en1), .FrameDone(fd1)
    );
    seg7_scan_ctrl #(.NUM_DIGITS(N2), .DWELL_CYCLES(D2), .GUARD_CYCLES(G2)) u_dut2 (
        .Clk(clk), .Rst(rst[2]), .LoadValid(valid[2]), .LoadReady(rdy2),
        .LoadValue(val[2][4*N2-1:0]), .LoadDp(dp[2][N2-1:0]), .BlankLeading(blank[2]),
        .SegOut(seg2), .DigitEn(en2), .FrameDone(fd2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: running flag, position within frame, shown and pending values.
    bit          m_run   [NI];
    int          m_pos   [NI];
    logic [31:0] m_dval  [NI];
    logic [7:0]  m_ddp   [NI];
    bit          m_dblank[NI];
    bit          m_pfull [NI];
    logic [31:0] m_pval  [NI];
    logic [7:0]  m_pdp   [NI];
    bit          m_pblank[NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    function automatic int period(input int k);
        return P_N[k] * (P_D[k] + P_G[k]);
    endfunction

    task automatic model_commit(input int k);
        m_dval[k]   = m_pval[k];
        m_ddp[k]    = m_pdp[k];
        m_dblank[k] = m_pblank[k];
        m_pfull[k]  = 1'b0;
    endtask

    task automatic model_edge(input int k);
        bit xfer;
        if (rst[k]) begin
            m_run[k] = 0; m_pos[k] = 0; m_pfull[k] = 0;
            m_dval[k] = '0; m_ddp[k] = '0; m_dblank[k] = 0;
            m_pval[k] = '0; m_pdp[k] = '0; m_pblank[k] = 0;
            return;
        end
        xfer = valid[k] && !m_pfull[k];
        if (!m_run[k]) begin
            if (m_pfull[k]) begin
                model_commit(k);
                m_run[k] = 1;
                m_pos[k] = 0;
            end
        end else if (m_pos[k] == period(k) - 1) begin
            m_pos[k] = 0;
            if (m_pfull[k]) model_commit(k);
        end else begin
            m_pos[k]++;
        end
        if (xfer) begin
            m_pval[k]   = val[k];
            m_pdp[k]    = dp[k];
            m_pblank[k] = blank[k];
            m_pfull[k]  = 1'b1;
        end
    endtask

    task automatic check_outputs(input int k);
        logic [7:0] e_seg, e_en, o_seg, o_en;
        logic       e_fd, o_fd, o_rdy;
        int         slot, digit, ph;
        e_seg = '0; e_en = '0; e_fd = 1'b0;
        if (m_run[k]) begin
            slot  = P_D[k] + P_G[k];
            digit = m_pos[k] / slot;
            ph    = m_pos[k] % slot;
            e_fd  = (m_pos[k] == period(k) - 1);
            if (ph < P_D[k]) begin
                e_en = 8'd1 << digit;
                if (m_dblank[k] && digit > 0 && (m_dval[k] >> (4*digit)) == 0)
                    e_seg[6:0] = 7'h00;
                else
                    e_seg[6:0] = hex_glyph(4'(m_dval[k] >> (4*digit)));
                e_seg[7] = m_ddp[k][digit];
            end
        end
        case (k)
            0:       begin o_seg = seg0; o_en = 8'(en0); o_fd = fd0; o_rdy = rdy0; end
            1:       begin o_seg = seg1; o_en = 8'(en1); o_fd = fd1; o_rdy = rdy1; end
            default: begin o_seg = seg2; o_en = 8'(en2); o_fd = fd2; o_rdy = rdy2; end
        endcase
        check($sformatf("u%0d.SegOut", k),    32'(o_seg), 32'(e_seg));
        check($sformatf("u%0d.DigitEn", k),   32'(o_en),  32'(e_en));
        check($sformatf("u%0d.FrameDone", k), 32'(o_fd),  32'(e_fd));
        check($sformatf("u%0d.LoadReady", k), 32'(o_rdy), 32'(!m_pfull[k]));
    endtask

    function automatic logic [31:0] rand_value(input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic drive(input int k, input int cyc);
        rst[k] = (cyc < 3) || ($urandom_range(0, 249) == 0);
        if (cyc == 3) begin
            // Known first values: F5 / 0050 blanked with dp on digit 2 / 5F.
            valid[k] = 1'b1;
            val[k]   = (k == 1) ? 32'h0050 : ((k == 0) ? 32'hF5 : 32'h5F);
            dp[k]    = (k == 1) ? 8'b0100 : 8'h00;
            blank[k] = (k == 1);
            return;
        end
        // Bias transfers onto the boundary cycle itself to exercise the collision rule.
        if (m_run[k] && m_pos[k] == period(k) - 1 && !m_pfull[k])
            valid[k] = ($urandom_range(0, 1) == 0);
        else
            valid[k] = ($urandom_range(0, 3) == 0);
        val[k]   = rand_value(P_N[k]);
        dp[k]    = 8'($urandom) & (8'hFF >> (8 - P_N[k]));
        blank[k] = ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; valid[k] = 1'b0; blank[k] = 1'b0; val[k] = '0; dp[k] = '0;
            m_run[k] = 0; m_pos[k] = 0; m_pfull[k] = 0; m_dblank[k] = 0; m_pblank[k] = 0;
            m_dval[k] = '0; m_ddp[k] = '0; m_pval[k] = '0; m_pdp[k] = '0;
        end
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) model_edge(k);
            #1;
            for (int k = 0; k < NI; k++) check_outputs(k);
            for (int k = 0; k < NI; k++) drive(k, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
